// File: rtl/sha3_padder_if.sv
//------------------------------------------------------------------------------
// sha3_padder_if
// Byte-stream input and padded-block output of the SHA-3 padder.
//   in_data/in_valid/in_last/in_flush -> padder, in_ready <- padder
//   block/block_valid/block_last <- padder, block_ready -> padder
// Modports: slave = padder side, master = producer/consumer side.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface sha3_padder_if #(
    parameter int unsigned R = 576
);
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_flush;
    logic         in_ready;
    logic [R-1:0] block;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport slave (
        input  in_data, in_valid, in_last, in_flush, block_ready,
        output in_ready, block, block_valid, block_last
    );

    modport master (
        output in_data, in_valid, in_last, in_flush, block_ready,
        input  in_ready, block, block_valid, block_last
    );
endinterface

// File: rtl/sha3_padder.sv
//------------------------------------------------------------------------------
// sha3_padder
// Packs a message byte stream into R-bit rate blocks and applies SHA-3
// multi-rate padding (DOMAIN byte, zero fill, final 0x80).
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : sha3_padder_if.slave (byte input handshake, block output
//            handshake, block_last marks the final padded block)
// Byte k of a block sits at block[R-1-8k -: 8].
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sha3_padder #(
    parameter int unsigned D      = 512,
    parameter logic [7:0]  DOMAIN = 8'h06
) (
    input  logic          clk,
    input  logic          reset,
    sha3_padder_if.slave  bus
);
    localparam int unsigned R  = 1600 - 2 * D;
    localparam int unsigned NB = R / 8;
    localparam int unsigned CW = $clog2(NB);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_HOLD
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic                 r_pend_pad;
    logic                 r_valid;
    logic                 r_last;
    logic [NB-1:0][7:0]   r_mem;

    logic [NB-1:0][7:0]   w_pad;
    logic [R-1:0]         w_block;
    logic                 w_end;
    logic                 w_full;

    // A flush alongside a valid byte simply marks that byte as the last one.
    assign w_end  = bus.in_last | bus.in_flush;
    assign w_full = (r_cnt == CW'(NB - 1));

    // Padded image of the buffer: slots below cnt keep data, the rest are
    // zeroed, DOMAIN lands at slot cnt and 0x80 is OR-ed into the final slot.
    for (genvar g = 0; g < NB; g++) begin : g_pad
        always_comb begin
            w_pad[g] = (r_cnt > CW'(g)) ? r_mem[g] : 8'h00;
            if (r_cnt == CW'(g)) begin
                w_pad[g] = w_pad[g] | DOMAIN;
            end
            if (g == NB - 1) begin
                w_pad[g] = w_pad[g] | 8'h80;
            end
        end
        assign w_block[(NB-1-g)*8 +: 8] = r_mem[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FILL;
            r_cnt      <= '0;
            r_pend_pad <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_mem      <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (bus.in_valid) begin
                        r_mem[r_cnt] <= bus.in_data;
                        if (w_full) begin
                            // Block is full of data; a last byte here means
                            // the padding needs a block of its own.
                            r_state    <= ST_HOLD;
                            r_valid    <= 1'b1;
                            r_last     <= 1'b0;
                            r_pend_pad <= w_end;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            if (w_end) begin
                                r_state <= ST_PAD;
                            end
                        end
                    end else if (bus.in_flush) begin
                        r_state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    r_mem      <= w_pad;
                    r_state    <= ST_HOLD;
                    r_valid    <= 1'b1;
                    r_last     <= 1'b1;
                    r_pend_pad <= 1'b0;
                end
                ST_HOLD: begin
                    if (bus.block_ready) begin
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_state <= r_pend_pad ? ST_PAD : ST_FILL;
                    end
                end
                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.in_ready    = (r_state == ST_FILL) && !reset;
    assign bus.block       = w_block;
    assign bus.block_valid = r_valid;
    assign bus.block_last  = r_last;

endmodule

// File: tb/tb_sha3_padder.sv
`timescale 1ns/1ps
module tb_sha3_padder;
    localparam int unsigned NB  = 72;
    localparam int unsigned R   = NB * 8;
    localparam logic [7:0]  DOM = 8'h06;

    typedef struct {
        logic [R-1:0] data;
        logic         last;
    } blk_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha3_padder_if #(.R(R)) bus();

    sha3_padder #(.D(512), .DOMAIN(DOM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          n_checks  = 0;
    int          n_pass    = 0;
    int          cons_mode = 0;
    int          hold_cnt  = 0;
    blk_t        exp_q[$];
    blk_t        mdl_q[$];
    logic [7:0]  msg_q[$];

    task automatic chk(input string name, input logic [R-1:0] act, input logic [R-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: DUT did not respond within the cycle budget", name);
    endtask

    // Reference padding: append DOMAIN, zero-fill to a whole number of
    // blocks (always at least one byte of padding), OR 0x80 into the end.
    task automatic build_model();
        int unsigned L;
        int unsigned nblk;
        logic [7:0]  pb[$];
        blk_t        b;
        L    = msg_q.size();
        nblk = L / NB + 1;
        mdl_q.delete();
        for (int unsigned i = 0; i < nblk * NB; i++) pb.push_back(8'h00);
        for (int unsigned i = 0; i < L; i++) pb[i] = msg_q[i];
        pb[L] = pb[L] | DOM;
        pb[nblk*NB-1] = pb[nblk*NB-1] | 8'h80;
        for (int unsigned bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int unsigned k = 0; k < NB; k++)
                b.data = (b.data << 8) | R'(pb[bi*NB+k]);
            b.last = (bi == nblk - 1);
            mdl_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_accept(input string name);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            k++;
            if (k > 3000) begin timeout(name); break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input logic flush);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        bus.in_flush = flush;
        wait_accept("byte_accept");
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_flush = 1'b0;
    endtask

    task automatic send_flush();
        bus.in_flush = 1'b1;
        wait_accept("flush_accept");
        bus.in_flush = 1'b0;
    endtask

    // mode 0: in_last on final byte, 1: in_flush with final byte, 2: separate flush
    task automatic send_msg(input int mode, input bit gaps);
        build_model();
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        if (msg_q.size() == 0) mode = 2;
        foreach (msg_q[i]) begin
            if (gaps) idle($urandom_range(0, 2));
            if (i == msg_q.size() - 1 && mode != 2) send_byte(msg_q[i], mode == 0, mode == 1);
            else send_byte(msg_q[i], 1'b0, 1'b0);
        end
        if (mode == 2) send_flush();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin @(posedge clk); #1; k++; end
        chk("drain_queue", R'(exp_q.size()), '0);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (bus.block_valid !== 1'b1 && k < 1000) begin @(posedge clk); #1; k++; end
        if (k >= 1000) timeout("wait_block_valid");
    endtask

    // Consumer: 0 random ready, 1 hold ready low 10 cycles per block, 2 never ready
    initial begin
        bus.block_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (cons_mode)
                0: bus.block_ready = 1'($urandom_range(0, 1));
                1: begin
                    if (bus.block_valid === 1'b1) begin
                        hold_cnt++;
                        bus.block_ready = (hold_cnt > 10);
                    end else begin
                        hold_cnt = 0;
                        bus.block_ready = 1'b0;
                    end
                end
                default: bus.block_ready = 1'b0;
            endcase
        end
    end

    // Output checker against the expected-block queue
    initial begin
        logic         prev_hold;
        logic [R-1:0] prev_blk;
        prev_hold = 1'b0;
        prev_blk  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else if (bus.block_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_block: block_valid=1 required 0 (no block expected)");
                end else begin
                    chk("block_data", bus.block, exp_q[0].data);
                    chk("block_last", R'(bus.block_last), R'(exp_q[0].last));
                end
                chk("in_ready_in_hold", R'(bus.in_ready), '0);
                if (prev_hold) chk("block_stable", bus.block, prev_blk);
                if (bus.block_ready === 1'b1) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    prev_hold = 1'b0;
                end else begin
                    prev_hold = 1'b1;
                    prev_blk  = bus.block;
                end
            end else begin
                if (prev_hold) begin
                    n_checks++;
                    $display("FAIL valid_dropped: block_valid=0 required 1 before handshake");
                end
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [R-1:0] lit;
        logic [R-1:0] t;
        int           len;
        int           sel;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_flush = 1'b0;
        lit = '0;
        lit[R-1 -: 8] = 8'h06;
        lit[7:0]      = 8'h80;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", R'(bus.in_ready), '0);
        chk("reset_block_valid", R'(bus.block_valid), '0);
        chk("reset_block_last", R'(bus.block_last), '0);
        chk("reset_block", bus.block, '0);
        reset = 1'b0;
        #1;
        chk("fill_in_ready", R'(bus.in_ready), R'(1'b1));

        // Empty message via flush
        msg_q.delete();
        build_model();
        chk("model_empty_count", R'(mdl_q.size()), R'(1));
        chk("model_empty_data", mdl_q[0].data, lit);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        send_flush();
        chk("flush_pad_cycle_valid", R'(bus.block_valid), '0);
        @(posedge clk); #1;
        chk("flush_latency_valid", R'(bus.block_valid), R'(1'b1));
        drain();

        // "abc"
        cons_mode = 2;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(0, 1'b0);
        wait_valid();
        chk("abc_head", R'(bus.block[R-1 -: 32]), R'(32'h61626306));
        chk("abc_tail", R'(bus.block[R-33 -: 32]), '0);
        chk("abc_end", R'(bus.block[7:0]), R'(8'h80));
        cons_mode = 0;
        drain();

        // 71 bytes: DOMAIN and 0x80 share the last slot
        msg_q.delete();
        for (int i = 0; i < 71; i++) msg_q.push_back(8'(i));
        build_model();
        t = mdl_q[0].data;
        chk("model_71_last_slot", R'(t[7:0]), R'(8'h86));
        chk("model_71_slot70", R'(t[15:8]), R'(8'h46));
        send_msg(0, 1'b1);
        drain();

        // 72 bytes: raw block, then a padding-only block
        msg_q.delete();
        for (int i = 0; i < 72; i++) msg_q.push_back(8'($urandom));
        build_model();
        chk("model_72_count", R'(mdl_q.size()), R'(2));
        chk("model_72_pad_block", mdl_q[1].data, lit);
        cons_mode = 2;
        send_msg(0, 1'b0);
        chk("full_block_latency", R'(bus.block_valid), R'(1'b1));
        chk("full_block_not_last", R'(bus.block_last), '0);
        cons_mode = 0;
        drain();

        // 144 bytes under back-pressure
        cons_mode = 1;
        msg_q.delete();
        for (int i = 0; i < 144; i++) msg_q.push_back(8'($urandom));
        send_msg(0, 1'b0);
        drain();
        cons_mode = 0;

        // Reset after 30 bytes, then "abc"
        for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midreset_valid", R'(bus.block_valid), '0);
        chk("midreset_in_ready", R'(bus.in_ready), '0);
        idle(3);
        reset = 1'b0;
        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(0, 1'b1);
        drain();

        // Reset while a block is held
        cons_mode = 2;
        msg_q.delete();
        for (int i = 0; i < 72; i++) msg_q.push_back(8'($urandom));
        build_model();
        exp_q.push_back(mdl_q[0]);
        foreach (msg_q[i]) send_byte(msg_q[i], 1'b0, 1'b0);
        wait_valid();
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", R'(bus.block_valid), '0);
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        #1;
        chk("post_reset_block", bus.block, '0);
        chk("post_reset_in_ready", R'(bus.in_ready), R'(1'b1));
        cons_mode = 0;

        // Randomized messages
        for (int m = 0; m < 25; m++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: len = 0;
                1: len = NB - 1;
                2: len = NB;
                3: len = 2 * NB;
                default: len = $urandom_range(1, 160);
            endcase
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            send_msg($urandom_range(0, 2), 1'b1);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sha3_padder.md
Name: sha3_padder

Overview:
- Upstream stage of the keccak sponge core.
- Accepts a message as a byte stream over a valid/ready handshake and packs bytes into rate-sized blocks (R bits).
- Applies SHA-3 multi-rate padding (domain byte, zero fill, final 0x80) in hardware, then presents each block on a valid/ready interface.
- A block_last flag marks the final padded block so the controller knows when to squeeze the digest.

Parameters:
- D, 512, digest width in bits (224/256/384/512 supported).
- R, 1600-2*D, rate in bits (derived; do not override). NB = R/8 bytes per block.
- DOMAIN, 8'h06, domain-separation pad byte (8'h1F for SHAKE).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  message byte.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies in_data as the final message byte.
- in_flush  input  1  ends the message with no byte (used for a zero-length tail).
- in_ready  output  1  byte accepted when in_valid && in_ready.
- block  output  R  assembled block. First byte of the block is at block[R-1:R-8]; byte k is at block[R-1-8k -: 8].
- block_valid  output  1  block holds a complete block.
- block_ready  input  1  consumer takes the block when block_valid && block_ready.
- block_last  output  1  block is the final padded block of the message.

Behaviour:
- Reset (async): state=FILL, cnt=0, pend_pad=0, block='0, block_valid=0, block_last=0. in_ready=0 while reset is high.
- State FILL:
  - in_ready=1.
  - On accept: buf[cnt] <= in_data, cnt++.
  - Byte lands in slot NB-1, in_last=0: go to HOLD, block_last=0.
  - Byte lands in slot NB-1, in_last=1: go to HOLD, block_last=0, pend_pad=1 (an extra pad block follows).
  - Byte lands in slot <NB-1, in_last=1: go to PAD.
  - in_flush && !in_valid: go to PAD, no byte written.
  - in_valid && in_flush together: treat as byte with in_last=1; flush has no further effect.
- State PAD (exactly one cycle, in_ready=0):
  - Bytes at positions >= cnt <= 8'h00.
  - buf[cnt] |= DOMAIN.
  - buf[NB-1] |= 8'h80. If cnt==NB-1 the slot becomes DOMAIN|0x80 (0x86 for SHA-3).
  - Then go to HOLD with block_last=1, pend_pad=0.
- State HOLD:
  - block_valid=1, in_ready=0.
  - block and block_last stay stable until handshake.
  - On block_valid && block_ready: cnt <= 0; block_valid deasserts next cycle.
  - Next state is PAD if pend_pad=1, else FILL.
  - Stale buffer contents need not be cleared; every slot is overwritten by data or by PAD.
- Latency:
  - Full data block: block_valid rises on the edge after the NB-th byte is accepted.
  - Final partial block: block_valid rises 2 edges after the last byte or flush (one PAD cycle).
  - Post-handshake: earliest next byte acceptance is the cycle after the handshake.
- Throughput: at most one byte per cycle. No internal double buffering; the upstream source stalls during PAD and HOLD.
- Reset mid-operation: partial block discarded immediately; block_valid drops asynchronously. The next message starts at slot 0.
- Counter width is $clog2(NB). cnt never exceeds NB-1 and never wraps outside a handshake.

Test Plan (D=512, R=576, NB=72):
1. Reset released, in_flush pulsed with no bytes -> one block: byte0=0x06, bytes1..70=0x00, byte71=0x80; block_last=1; block_valid rises 2 cycles after flush.
2. Bytes 61 62 63 ("abc"), in_last on 0x63 -> block = 61 62 63 06 followed by 67 bytes of 00, then 80; block_last=1. Feeding the keccak core yields the SHA3-512("abc") digest b751850b...
3. 71 bytes with values 0x00..0x46, in_last on 0x46 -> byte71=0x86, bytes0..70 unchanged, block_last=1.
4. 72 bytes with in_last on the 72nd -> first block holds the raw data with block_last=0. After handshake, a second block 06, 00 x70, 80 with block_last=1.
5. 144-byte message, block_ready held low 10 cycles on each block -> block stable, in_ready=0, no byte lost or duplicated. Three blocks total; only the third has block_last=1.
6. reset asserted after 30 bytes accepted, then "abc" sent -> block_valid=0 during reset; the resulting block is identical to scenario 2.
